// File: rtl/cla_pkg.sv
// Shared types and helpers for the slice-based carry-lookahead adder.
// A slice is SLICE_W bits wide; a slice_pg_t carries its block propagate/generate.
package cla_pkg;

  localparam int unsigned SLICE_W    = 4;
  localparam int unsigned MAX_SLICES = 4;

  typedef struct packed {
    logic p;
    logic g;
  } slice_pg_t;

  // Block propagate/generate of one 4-bit slice from its two operand nibbles.
  function automatic slice_pg_t slice_pg(input logic [SLICE_W-1:0] a4,
                                         input logic [SLICE_W-1:0] b4);
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    slice_pg_t          r;
    p   = a4 ^ b4;
    g   = a4 & b4;
    r.p = &p;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/lcu4.sv
// Four-input lookahead carry unit: slice carries c[4:1] from block P/G and a carry-in,
// plus group propagate/generate across all four inputs.
module lcu4 (
  input  logic [3:0] p_i,
  input  logic [3:0] g_i,
  input  logic       cin_i,
  output logic [4:1] c_o,
  output logic       gp_o,
  output logic       gg_o
);

  // Fully expanded two-level lookahead; no ripple between the four carries.
  always_comb begin
    c_o[1] = g_i[0] | (p_i[0] & cin_i);
    c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
    c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & cin_i);
    c_o[4] = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
           | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
           | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & cin_i);
    gp_o   = &p_i;
    gg_o   = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
           | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
  end

endmodule

// File: rtl/cla16_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Stage 1 registers bitwise and per-slice P/G; stage 2 resolves carries through lcu4
// and registers sum, carry-out and group P/G.
// Optional feature macro CLA16_SUB_EN: adds 'sub' input (a + ~b + 1) and registered
// signed 'overflow' output.
module cla16_pipe
  import cla_pkg::*;
#(
  // Number of 4-bit slices, 1..MAX_SLICES.
  parameter int unsigned NUM_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] a,
  input  logic [SLICE_W*NUM_SLICES-1:0] b,
  input  logic                          carryInput,
`ifdef CLA16_SUB_EN
  input  logic                          sub,
  output logic                          overflow,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] sum,
  output logic                          carryOutput,
  output logic                          prop,
  output logic                          gene
);

  localparam int unsigned W = SLICE_W * NUM_SLICES;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q;
  logic out_valid_q;
  logic s2_free;
  logic accept;
  logic s1_adv;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && s2_free;

  // ---------------------------------------------------------------------------
  // Stage 1: operand conditioning and slice P/G
  // ---------------------------------------------------------------------------
  logic [W-1:0]          b_eff;
  logic                  cin_eff;
  logic [W-1:0]          p_d;
  logic [W-1:0]          g_d;
  logic [NUM_SLICES-1:0] sp_d;
  logic [NUM_SLICES-1:0] sg_d;

`ifdef CLA16_SUB_EN
  // Subtraction is a + ~b + 1; the external carry-in is not used then.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : carryInput;
`else
  assign b_eff   = b;
  assign cin_eff = carryInput;
`endif

  // Bitwise propagate/generate and per-slice block P/G for the incoming operands.
  always_comb begin
    slice_pg_t pg;
    p_d  = a ^ b_eff;
    g_d  = a & b_eff;
    sp_d = '0;
    sg_d = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      pg      = slice_pg(a[SLICE_W*k +: SLICE_W], b_eff[SLICE_W*k +: SLICE_W]);
      sp_d[k] = pg.p;
      sg_d[k] = pg.g;
    end
  end

  logic [W-1:0]          s1_p_q;
  logic [W-1:0]          s1_g_q;
  logic [NUM_SLICES-1:0] s1_sp_q;
  logic [NUM_SLICES-1:0] s1_sg_q;
  logic                  s1_cin_q;

  // S1 loads on accept and empties when it advances without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_sp_q    <= '0;
      s1_sg_q    <= '0;
      s1_cin_q   <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_p_q     <= p_d;
        s1_g_q     <= g_d;
        s1_sp_q    <= sp_d;
        s1_sg_q    <= sg_d;
        s1_cin_q   <= cin_eff;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: second-level lookahead and sum formation
  // ---------------------------------------------------------------------------
  logic [3:0] lcu_p;
  logic [3:0] lcu_g;
  logic [4:1] lcu_c;
  logic       lcu_gp;
  logic       lcu_gg;
  logic [4:0] slice_cin;

  // Unused upper slices are transparent: P=1, G=0.
  always_comb begin
    lcu_p = '1;
    lcu_g = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      lcu_p[k] = s1_sp_q[k];
      lcu_g[k] = s1_sg_q[k];
    end
  end

  lcu4 u_lcu4 (
    .p_i   (lcu_p),
    .g_i   (lcu_g),
    .cin_i (s1_cin_q),
    .c_o   (lcu_c),
    .gp_o  (lcu_gp),
    .gg_o  (lcu_gg)
  );

  assign slice_cin = {lcu_c, s1_cin_q};

  logic [W-1:0] sum_d;
`ifdef CLA16_SUB_EN
  logic         c_msb_in;
`endif

  // Per-bit carries ripple only within a slice, seeded by that slice's lookahead carry.
  always_comb begin
    logic c;
    sum_d = '0;
    c     = 1'b0;
`ifdef CLA16_SUB_EN
    c_msb_in = 1'b0;
`endif
    for (int k = 0; k < NUM_SLICES; k++) begin
      c = slice_cin[k];
      for (int j = 0; j < SLICE_W; j++) begin
        sum_d[SLICE_W*k + j] = s1_p_q[SLICE_W*k + j] ^ c;
`ifdef CLA16_SUB_EN
        if (SLICE_W*k + j == W - 1) c_msb_in = c;
`endif
        c = s1_g_q[SLICE_W*k + j] | (s1_p_q[SLICE_W*k + j] & c);
      end
    end
  end

  logic [W-1:0] sum_q;
  logic         co_q;
  logic         prop_q;
  logic         gene_q;
`ifdef CLA16_SUB_EN
  logic         ovf_q;
`endif

  // S2 reloads whenever S1 advances; otherwise it holds until the result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      prop_q      <= 1'b0;
      gene_q      <= 1'b0;
`ifdef CLA16_SUB_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        out_valid_q <= 1'b1;
        sum_q       <= sum_d;
        co_q        <= slice_cin[NUM_SLICES];
        prop_q      <= lcu_gp;
        gene_q      <= lcu_gg;
`ifdef CLA16_SUB_EN
        ovf_q       <= slice_cin[NUM_SLICES] ^ c_msb_in;
`endif
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign sum         = sum_q;
  assign carryOutput = co_q;
  assign prop        = prop_q;
  assign gene        = gene_q;
`ifdef CLA16_SUB_EN
  assign overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_cla16_pipe.sv
// Self-checking bench for cla16_pipe: arithmetic reference model with an ordered
// expectation queue, plus directed vectors with literal expectations.
module tb_cla16_pipe;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carryInput;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryOutput;
  logic         prop;
  logic         gene;
  logic         sub_v;
  logic         ovf_v;
`ifdef CLA16_SUB_EN
  logic         overflow;
  assign ovf_v = overflow;
`else
  assign ovf_v = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  cla16_pipe #(
    .NUM_SLICES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .carryInput  (carryInput),
`ifdef CLA16_SUB_EN
    .sub         (sub_v),
    .overflow    (overflow),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .carryOutput (carryOutput),
    .prop        (prop),
    .gene        (gene)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         p;
    logic         g;
    logic         ov;
  } exp_t;

  // Reference: plain integer addition; group P means every bit propagates,
  // group G means a carry-out arises even with zero carry-in.
  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vc, input logic vs);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    logic [W:0]   nocin;
    exp_t         e;
    bb    = vs ? ~vb : vb;
    c     = vs ? 1'b1 : vc;
    full  = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, c};
    nocin = {1'b0, va} + {1'b0, bb};
    e.s   = full[W-1:0];
    e.co  = full[W];
    e.p   = ((va ^ bb) == {W{1'b1}});
    e.g   = nocin[W];
`ifdef CLA16_SUB_EN
    e.ov  = (va[W-1] == bb[W-1]) && (e.s[W-1] != va[W-1]);
`else
    e.ov  = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Ordered expectations: pushed on accept, popped when the result is taken.
  exp_t mq[$];

  always @(negedge clk) begin
    exp_t got;
    if (rst) begin
      mq.delete();
    end else begin
      if (out_valid) begin
        got = '{s: sum, co: carryOutput, p: prop, g: gene, ov: ovf_v};
        checks++;
        if (mq.size() == 0) begin
          failures++;
          $display("FAIL stray_result actual=%h required=none", got);
        end else begin
          if (got !== mq[0]) begin
            failures++;
            $display("FAIL model_cmp actual=%h required=%h", got, mq[0]);
          end
          if (out_ready) void'(mq.pop_front());
        end
      end
      if (in_valid && in_ready) mq.push_back(model(a, b, carryInput, sub_v));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // One op through an idle pipe with literal expectations; called 1 time unit after posedge.
  task automatic run_vec(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic vs, input logic [W-1:0] es,
                         input logic eco, input logic ep, input logic eg, input logic eov);
    out_ready  = 1'b1;
    a          = va;
    b          = vb;
    carryInput = vc;
    sub_v      = vs;
    in_valid   = 1'b1;
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sub_v    = 1'b0;
    chk({nm, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({nm, "_cout"}, {31'd0, carryOutput}, {31'd0, eco});
    chk({nm, "_prop"}, {31'd0, prop}, {31'd0, ep});
    chk({nm, "_gene"}, {31'd0, gene}, {31'd0, eg});
    if (vs) chk({nm, "_ovf"}, {31'd0, ovf_v}, {31'd0, eov});
  endtask

  logic [W-1:0] ta [6];
  logic [W-1:0] tb [6];
  logic         tc [6];

  initial begin
    int idx;
    int cyc;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carryInput = 1'b0;
    out_ready = 1'b0; sub_v = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout_prop_gene", {29'd0, carryOutput, prop, gene}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed vectors
    run_vec("v1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("v2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("v3", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef CLA16_SUB_EN
    run_vec("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("sub2", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b1);
`endif
    @(posedge clk); #1;

    // Back-to-back under backpressure
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; carryInput = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h00F1;
    @(posedge clk); #1;
    a = 16'h8000; b = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_sum", {16'd0, sum}, 32'h3333);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second", {16'd0, sum}, 32'h1000);
    chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("bp_third", {15'd0, carryOutput, sum}, 32'h10000);
    @(posedge clk); #1;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0002; b = 16'h0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_full_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
    run_vec("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

    // Streamed vectors with intermittent backpressure, checked by the model
    ta[0] = 16'h7FFF; tb[0] = 16'h0001; tc[0] = 1'b0;
    ta[1] = 16'hAAAA; tb[1] = 16'h5555; tc[1] = 1'b1;
    ta[2] = 16'h0F0F; tb[2] = 16'hF0F0; tc[2] = 1'b0;
    ta[3] = 16'hFFFF; tb[3] = 16'hFFFF; tc[3] = 1'b1;
    ta[4] = 16'h0000; tb[4] = 16'h0000; tc[4] = 1'b0;
    ta[5] = 16'h8421; tb[5] = 16'h7BDE; tc[5] = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 100) begin
      a = ta[idx]; b = tb[idx]; carryInput = tc[idx]; in_valid = 1'b1;
      out_ready = (cyc % 3 != 1);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    chk("stream_all_accepted", idx, 32'd6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("stream_queue_empty", mq.size(), 32'd0);
    chk("stream_idle", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
